// File: rtl/regfile_rename_pkg.sv
// Shared configuration for the renaming architectural register file.
// Holds bus widths, register count, the reserved "no tag" nick and the
// element typedefs used by the top and its read ports.
package regfile_rename_pkg;

  localparam int unsigned RegNum  = 32;  // architectural registers, x0 hardwired zero
  localparam int unsigned NameBus = 5;   // register-name width
  localparam int unsigned NickBus = 5;   // ROB nick width
  localparam int unsigned DataBus = 32;  // data width

  typedef logic [NameBus-1:0] name_t;
  typedef logic [NickBus-1:0] nick_t;
  typedef logic [DataBus-1:0] data_t;

  // Nick 0 is never allocated by the ROB; a tag of 0 means "value is ready".
  localparam nick_t NickNone = '0;

endpackage

// File: rtl/rf_read_port.sv
// Combinational source-operand lookup for dispatch.
// Ports:
//   regnm_i    - register being read
//   dt_arr_i   - architectural values
//   tag_arr_i  - pending nicks, NickNone when ready
//   cm_en_i, cm_regnm_i, cm_dt_i, cm_nick_i - same-cycle commit, used for bypass
//   dt_o       - operand value (meaningful when nick_o == NickNone)
//   nick_o     - pending nick, NickNone = ready
module rf_read_port
  import regfile_rename_pkg::*;
(
  input  name_t regnm_i,
  input  data_t dt_arr_i  [RegNum],
  input  nick_t tag_arr_i [RegNum],
  input  logic  cm_en_i,
  input  name_t cm_regnm_i,
  input  data_t cm_dt_i,
  input  nick_t cm_nick_i,
  output data_t dt_o,
  output nick_t nick_o
);

  data_t cur_dt;
  nick_t cur_tag;

  assign cur_dt  = dt_arr_i[regnm_i];
  assign cur_tag = tag_arr_i[regnm_i];

  always_comb begin
    dt_o   = cur_dt;
    nick_o = cur_tag;
    if (regnm_i == '0) begin
      dt_o   = '0;
      nick_o = NickNone;
    end else if (cur_tag == NickNone) begin
      dt_o   = cur_dt;
      nick_o = NickNone;
    end else if (cm_en_i && (cm_regnm_i == regnm_i) && (cm_nick_i == cur_tag)) begin
      // The producer is committing right now: forward its value so dispatch
      // does not wait a cycle for the register file write.
      dt_o   = cm_dt_i;
      nick_o = NickNone;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags (ROB nicks).
// Ports:
//   clk, rst (async, active-low), rdy (global enable; low freezes state)
//   iclr                          - flush, clears every pending tag
//   iROB_nick_en/_nick/_nick_regnm - rename: mark destination busy with a nick
//   iCM_en/_regnm/_dt/_nick        - commit: write value, release matching tag
//   iDP_rs{1,2}_regnm             - dispatch source lookups
//   oDP_rs{1,2}_dt/_nick           - value, or pending nick (0 = ready)
module regfile_rename
  import regfile_rename_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               iclr,
  input  logic               iROB_nick_en,
  input  logic [NickBus-1:0] iROB_nick,
  input  logic [NameBus-1:0] iROB_nick_regnm,
  input  logic               iCM_en,
  input  logic [NameBus-1:0] iCM_regnm,
  input  logic [DataBus-1:0] iCM_dt,
  input  logic [NickBus-1:0] iCM_nick,
  input  logic [NameBus-1:0] iDP_rs1_regnm,
  output logic [DataBus-1:0] oDP_rs1_dt,
  output logic [NickBus-1:0] oDP_rs1_nick,
  input  logic [NameBus-1:0] iDP_rs2_regnm,
  output logic [DataBus-1:0] oDP_rs2_dt,
  output logic [NickBus-1:0] oDP_rs2_nick
);

  data_t dt_q  [RegNum];
  data_t dt_d  [RegNum];
  nick_t tag_q [RegNum];
  nick_t tag_d [RegNum];

  logic cm_wr;
  logic rn_wr;

  // x0 is never written or renamed.
  assign cm_wr = iCM_en && (iCM_regnm != '0);
  assign rn_wr = iROB_nick_en && (iROB_nick_regnm != '0) && !iclr;

  // Order matters: commit, then rename (wins over a same-register tag clear),
  // then flush. Flush only touches tags so the flushing branch's own commit
  // data still lands.
  always_comb begin
    dt_d  = dt_q;
    tag_d = tag_q;
    if (rdy) begin
      if (cm_wr) begin
        dt_d[iCM_regnm] = iCM_dt;
        if (tag_q[iCM_regnm] == iCM_nick) begin
          tag_d[iCM_regnm] = NickNone;
        end
      end
      if (rn_wr) begin
        tag_d[iROB_nick_regnm] = iROB_nick;
      end
      if (iclr) begin
        for (int unsigned i = 0; i < RegNum; i++) begin
          tag_d[i] = NickNone;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RegNum; i++) begin
        dt_q[i]  <= '0;
        tag_q[i] <= NickNone;
      end
    end else begin
      dt_q  <= dt_d;
      tag_q <= tag_d;
    end
  end

  rf_read_port u_rs1 (
    .regnm_i    (iDP_rs1_regnm),
    .dt_arr_i   (dt_q),
    .tag_arr_i  (tag_q),
    .cm_en_i    (iCM_en),
    .cm_regnm_i (iCM_regnm),
    .cm_dt_i    (iCM_dt),
    .cm_nick_i  (iCM_nick),
    .dt_o       (oDP_rs1_dt),
    .nick_o     (oDP_rs1_nick)
  );

  rf_read_port u_rs2 (
    .regnm_i    (iDP_rs2_regnm),
    .dt_arr_i   (dt_q),
    .tag_arr_i  (tag_q),
    .cm_en_i    (iCM_en),
    .cm_regnm_i (iCM_regnm),
    .cm_dt_i    (iCM_dt),
    .cm_nick_i  (iCM_nick),
    .dt_o       (oDP_rs2_dt),
    .nick_o     (oDP_rs2_nick)
  );

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags (ROB nicks); sits directly downstream of the reorder buffer.
- Consumes the ROB's nick-allocation outputs to mark destination registers busy.
- Consumes the ROB's commit outputs to write architectural values and release tags.
- Serves two source-operand lookups to dispatch: each returns either a ready value or the ROB nick still pending.
- Flush (mispredict) clears all pending tags.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
NAME_W, 5, register-name width
NICK_W, 5, ROB nick width; nick 0 reserved as "no tag / ready"
DATA_W, 32, data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-low
rdy  input  1  global enable; low freezes all state
iclr  input  1  flush from ROB; clears all tags
iROB_nick_en  input  1  rename request
iROB_nick  input  NICK_W  nick allocated to the destination
iROB_nick_regnm  input  NAME_W  destination register being renamed
iCM_en  input  1  commit write
iCM_regnm  input  NAME_W  committed destination register
iCM_dt  input  DATA_W  committed value
iCM_nick  input  NICK_W  nick of the committing entry
iDP_rs1_regnm  input  NAME_W  source 1 register
oDP_rs1_dt  output  DATA_W  source 1 value (valid when nick==0)
oDP_rs1_nick  output  NICK_W  source 1 pending nick, 0 = ready
iDP_rs2_regnm  input  NAME_W  source 2 register
oDP_rs2_dt  output  DATA_W  source 2 value
oDP_rs2_nick  output  NICK_W  source 2 pending nick

Behaviour:
- State: dt[REG_NUM] and tag[REG_NUM]; tag==0 means the register is ready.
- Reset (rst==0, async): all dt=0, all tag=0. Read outputs follow combinationally, so they read 0/0.
- Clock edge with rdy==1, updates applied in this order:
  - Commit: if iCM_en and iCM_regnm!=0, dt[iCM_regnm]<=iCM_dt. If additionally tag[iCM_regnm]==iCM_nick, tag<=0. A stale nick writes the value but leaves the tag.
  - Rename: if iROB_nick_en, iROB_nick_regnm!=0 and !iclr, tag[iROB_nick_regnm]<=iROB_nick. Rename overrides a same-cycle commit tag-clear on the same register.
  - Flush: if iclr, all tag<=0. Any commit data write in the same cycle still happens, because the mispredicting branch's own commit must land. Dt is never cleared by flush.
- rdy==0: no state change; reads remain combinational.
- Reads are combinational, zero latency, per port:
  - regnm==0 returns dt=0, nick=0.
  - Else if tag[r]==0, return dt[r], 0.
  - Else if iCM_en and iCM_regnm==r and iCM_nick==tag[r] (same-cycle bypass), return iCM_dt, 0.
  - Else return dt[r], tag[r].
- Reads never see a same-cycle rename, so "add x1,x1,x2" reads x1's prior tag/value.
- Reads ignore iclr; dispatch is flushed upstream.
- Commit of regnm 0: ignored entirely.
- Nick 0 on a rename is illegal. It is not checked; the effect is a ready marking.

Decomposition:
- Shared config header holds NameBus, NickBus, DataBus, RegNum, and the reserved NickNone=0; no new local constants.
- One natural sub-module, rf_read_port: the combinational lookup plus bypass, instantiated twice.
- The top module holds the arrays and the update logic.

Test Plan:
- Reset then read x5 -> dt=0, nick=0. Commit x5=0x1234 nick 0 with no tag set -> next cycle read x5 returns 0x1234/0.
- Rename x3 to nick 7; next cycle read x3 -> nick=7. Commit x3=0xDEAD nick 7, read in the same cycle -> bypass returns 0xDEAD/0. Following cycle, tag=0 and dt=0xDEAD.
- Rename x3 to nick 7, then rename x3 to nick 9, then commit x3=0xAA nick 7 -> dt=0xAA but read returns nick 9. Commit nick 9 value 0xBB -> returns 0xBB/0.
- Same-cycle commit x4 (nick 2, tag 2) and rename x4 to nick 5 -> afterwards tag=5, dt=commit value. Same-cycle read of x4 returns the bypassed value/0.
- Tags set on x1, x2, x6, then iclr together with commit x1=0x55 matching nick and rename x6 to nick 8 -> all tags 0, dt[1]=0x55, x6 rename dropped.
- Rename/commit to x0 -> read x0 always 0/0. With rdy=0, a rename and a commit leave state unchanged. Asserting rst low mid-sequence clears state immediately, without waiting for a clock edge.
